// File: rtl/sub_serial_ctrl_if.sv
// Operand/result handshake bundle for the serial subtract controller.
interface sub_serial_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             Z;

    // Requester side: issues operands, consumes results.
    modport master (
        output start_valid, A, B, B_in, res_ready,
        input  start_ready, res_valid, D, B_out, Z
    );

    // Controller side.
    modport slave (
        input  start_valid, A, B, B_in, res_ready,
        output start_ready, res_valid, D, B_out, Z
    );
endinterface

// File: rtl/sub_serial_ctrl.sv
// Serial A - B - B_in using one SLICE-bit ripple-borrow slice reused over
// WIDTH/SLICE cycles; the borrow between slices lives in a register.
module sub_serial_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic              clk,
    input  logic              rst,
    sub_serial_ctrl_if.slave  bus,
    output logic              busy
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               bor_q;
    logic [IDX_W-1:0]   idx_q;

    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE-1:0]   d_sl;
    logic [SLICE:0]     chain;
    logic [WIDTH-1:0]   d_next;

    // Select the operand slice addressed by the current index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
                a_sl = a_q[s*SLICE +: SLICE];
                b_sl = b_q[s*SLICE +: SLICE];
            end
        end
    end

    // Shared ripple-borrow slice built from per-bit full subtractors.
    always_comb begin
        chain    = '0;
        d_sl     = '0;
        chain[0] = bor_q;
        for (int i = 0; i < SLICE; i++) begin
            d_sl[i]     = a_sl[i] ^ b_sl[i] ^ chain[i];
            chain[i+1]  = (~a_sl[i] & b_sl[i]) | ((~a_sl[i] | b_sl[i]) & chain[i]);
        end
    end

    // Merge the fresh slice into the difference register image.
    always_comb begin
        d_next = bus.D;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDX_W'(s)) begin
                d_next[s*SLICE +: SLICE] = d_sl;
            end
        end
    end

    // Sequencer: accept, step one slice per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            bor_q           <= 1'b0;
            idx_q           <= '0;
            bus.D           <= '0;
            bus.B_out       <= 1'b0;
            bus.Z           <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.start_ready <= 1'b1;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q             <= bus.A;
                        b_q             <= bus.B;
                        bor_q           <= bus.B_in;
                        idx_q           <= '0;
                        bus.D           <= '0;
                        bus.start_ready <= 1'b0;
                        busy            <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    bus.D <= d_next;
                    bor_q <= chain[SLICE];
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NSLICE - 1)) begin
                        bus.B_out     <= chain[SLICE];
                        bus.Z         <= (d_next == '0);
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid   <= 1'b0;
                        bus.start_ready <= 1'b1;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    bus.res_valid   <= 1'b0;
                    bus.start_ready <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Randomized self-checking bench for sub_serial_ctrl against an arithmetic model.
module tb_sub_serial_ctrl;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 4;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    sub_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sub_serial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic prev_bout;
    logic prev_z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, borrow when the true result is negative.
    task automatic ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                           output logic [WIDTH-1:0] d, output logic bout, output logic z);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        bout = (diff < 0);
        if (diff < 0) diff = diff + (1 << WIDTH);
        d = WIDTH'(diff);
        z = (d == '0);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (bus.start_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("start_ready_wait", 32'(bus.start_ready), 32'd1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input int hold);
        logic [WIDTH-1:0] exp_d;
        logic [WIDTH-1:0] mask;
        logic             exp_b;
        logic             exp_z;
        int               lat;
        ref_sub(a, b, bin, exp_d, exp_b, exp_z);
        wait_ready();
        bus.start_valid = 1'b1;
        bus.A           = a;
        bus.B           = b;
        bus.B_in        = bin;
        tick();
        bus.start_valid = 1'b0;
        bus.A           = WIDTH'($urandom);
        bus.B           = WIDTH'($urandom);
        bus.B_in        = 1'($urandom);
        check("busy_run", 32'(busy), 32'd1);
        check("start_ready_run", 32'(bus.start_ready), 32'd0);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            if (lat < NSLICE) begin
                mask = '0;
                for (int i = 0; i < lat * SLICE; i++) mask[i] = 1'b1;
                check("partial_d", 32'(bus.D), 32'(exp_d & mask));
                check("bout_held", 32'(bus.B_out), 32'(prev_bout));
                check("z_held", 32'(bus.Z), 32'(prev_z));
            end
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(NSLICE));
        check("d", 32'(bus.D), 32'(exp_d));
        check("b_out", 32'(bus.B_out), 32'(exp_b));
        check("z", 32'(bus.Z), 32'(exp_z));
        bus.res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (h == hold / 2) begin
                bus.start_valid = 1'b1;
                bus.A           = WIDTH'($urandom);
                bus.B           = WIDTH'($urandom);
            end
            tick();
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_d", 32'(bus.D), 32'(exp_d));
            check("hold_bout", 32'(bus.B_out), 32'(exp_b));
            check("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("drain_valid", 32'(bus.res_valid), 32'd0);
        check("bubble_ready", 32'(bus.start_ready), 32'd1);
        check("bubble_busy", 32'(busy), 32'd0);
        prev_bout = exp_b;
        prev_z    = exp_z;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst             = 1'b1;
        bus.start_valid = 1'b1;
        bus.A           = 16'h1111;
        bus.B           = 16'h0001;
        bus.B_in        = 1'b0;
        bus.res_ready   = 1'b0;
        tick();
        tick();
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d", 32'(bus.D), 32'd0);
        check("rst_bout", 32'(bus.B_out), 32'd0);
        check("rst_z", 32'(bus.Z), 32'd0);
        bus.start_valid = 1'b0;
        rst             = 1'b0;
        prev_bout       = 1'b0;
        prev_z          = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 1);
        do_op(16'hABCD, 16'hABCD, 1'b1, 0);
        do_op(16'h5555, 16'h5555, 1'b0, 2);
        do_op(16'h8000, 16'h0001, 1'b0, 10);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
        do_op(16'h0000, 16'hFFFF, 1'b1, 0);

        // Reset after two slices are written: the operation must vanish.
        wait_ready();
        bus.start_valid = 1'b1;
        bus.A           = 16'h0F0F;
        bus.B           = 16'h00FF;
        bus.B_in        = 1'b0;
        tick();
        bus.start_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_ready", 32'(bus.start_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_d", 32'(bus.D), 32'd0);
        prev_bout = 1'b0;
        prev_z    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", 32'(bus.res_valid), 32'd0);
        end
        do_op(16'h0010, 16'h0011, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? ra : WIDTH'($urandom);
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sub_serial_ctrl.md
Name: sub_serial_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit unsigned subtraction A - B - B_in using a single SLICE-bit ripple-borrow subtractor slice, time-multiplexed over WIDTH/SLICE cycles.
- Slice is internal; each bit uses the team's full-subtractor equations.
- Borrow is carried between slices in a register.
- Valid/ready handshakes on both the operand side and the result side.
- Area-reduced alternative to the fully combinational 16-bit subtractor, for paths where latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle by the shared slice; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operands A, B, B_in are valid.
- start_ready  output  1  controller can accept an operation.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- B_in  input  1  borrow in.
- res_valid  output  1  D, B_out, Z hold a completed result.
- res_ready  input  1  consumer accepts the result.
- D  output  WIDTH  difference (A - B - B_in) mod 2^WIDTH.
- B_out  output  1  final borrow; 1 iff A < B + B_in (unsigned).
- Z  output  1  1 iff D == 0.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - D=0, B_out=0, Z=0, res_valid=0, busy=0, start_ready=1 from the next cycle.
  - Any in-flight operation is discarded with no result issued; rst overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: capture A, B into operand registers, borrow reg <= B_in, slice index <= 0, D <= 0, then go to RUN.
  - Inputs are ignored after capture.
- RUN:
  - start_ready=0.
  - Each cycle the slice computes on operand bits [idx*SLICE +: SLICE] with the borrow reg.
  - Per bit: d = a^b^bin; bout = (~a&b) | ((~a|b)&bin).
  - The slice result is written into D[idx*SLICE +: SLICE]; borrow reg <= slice borrow out; idx <= idx+1.
  - After the slice with idx == NSLICE-1 is written, go to DONE.
  - B_out <= final borrow; Z <= (completed D == 0).
- DONE:
  - res_valid=1; D, B_out, Z held stable.
  - On res_ready=1, go to IDLE next cycle and res_valid falls.
  - start_valid is not accepted in DONE; there is exactly one bubble cycle (IDLE) between operations.
- Latency:
  - Handshake sampled at edge E0; slices are written at edges E1..E_NSLICE.
  - res_valid is high starting the cycle after E_NSLICE, i.e. NSLICE cycles after acceptance (4 at default).
  - Throughput is one operation per NSLICE+2 cycles when res_ready is held high.
- Outputs during RUN:
  - D shows partially written slices (lower slices final, upper slices 0).
  - Consumers must qualify D with res_valid.
  - B_out and Z keep the previous operation's value until DONE.
- Wrap-around: D is modulo 2^WIDTH. Borrow ripples across slice boundaries only via the borrow reg; no combinational path spans more than one slice.
- Simultaneous events:
  - res_ready while not in DONE is ignored.
  - start_valid while not in IDLE is ignored; no queuing.
- Idx counter width: clog2(NSLICE), minimum 1 bit. Idx is reset to 0 on every accept.

Test Plan:
- Reset: hold rst 2 cycles with start_valid=1 -> start_ready=1, res_valid=0, busy=0, D=0, B_out=0, Z=0; no operation accepted during reset.
- Basic: A=16'h1234, B=16'h0FFF, B_in=0 -> res_valid high exactly 4 cycles after the accept edge; D=16'h0235, B_out=0, Z=0.
- Full borrow ripple: A=16'h0000, B=16'h0001, B_in=0 -> D=16'hFFFF, B_out=1, Z=0. Then A=B=16'hABCD, B_in=1 -> D=16'hFFFF, B_out=1.
- Zero result: A=B=16'h5555, B_in=0 -> D=16'h0000, B_out=0, Z=1.
- Backpressure and isolation, with operation A=16'h8000, B=16'h0001:
  - Hold res_ready=0 for 10 cycles -> res_valid, D=16'h7FFF, B_out=0 stay stable.
  - start_valid=1 meanwhile sees start_ready=0.
  - Changing A/B after acceptance does not alter the result.
  - After res_ready: one IDLE cycle, then the next operation is accepted.
- Reset mid-operation: assert rst after 2 slices are written -> IDLE next cycle, res_valid never rises for that operation. A following A=16'h0010, B=16'h0011 yields D=16'hFFFF, B_out=1.
